// File: rtl/bridge_sched_pkg.sv
// Shared types and constants for the DRAM<->SD bridge scheduler.
package bridge_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCollect,
        StResp
    } state_t;

    localparam int unsigned BR_BYTES            = 8;
    localparam int unsigned DRAM_AW             = 13;
    localparam int unsigned SD_AW               = 16;
    localparam int unsigned DATA_W              = 64;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 20000;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester above ptr, wrapping around.
module rr_arbiter #(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx
);

    logic            found;
    logic [ID_W-1:0] cand;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((32'(ptr) + k) % N_REQ);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                idx       = cand;
            end
        end
    end

endmodule

// File: rtl/bridge_scheduler.sv
// Shares one DRAM<->SD bridge among N_REQ requesters: arbitrate, issue one command,
// gather the 8-byte result burst and return it over a valid/ready response channel.
module bridge_scheduler
    import bridge_sched_pkg::*;
#(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned ID_W        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ-1:0]         req_dir,
    input  logic [N_REQ*DRAM_AW-1:0] req_addr_dram,
    input  logic [N_REQ*SD_AW-1:0]   req_addr_sd,
    output logic                     br_in_valid,
    output logic                     br_direction,
    output logic [DRAM_AW-1:0]       br_addr_dram,
    output logic [SD_AW-1:0]         br_addr_sd,
    input  logic                     br_out_valid,
    input  logic [7:0]               br_out_data,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic                     resp_dir,
    output logic [DATA_W-1:0]        resp_data,
    output logic                     busy,
    output logic [15:0]              done_cnt,
    output logic                     err_proto,
    output logic                     err_timeout
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               dir_q, dir_d;
    logic [DRAM_AW-1:0] dram_q, dram_d;
    logic [SD_AW-1:0]   sd_q, sd_d;
    logic               in_valid_q, in_valid_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [2:0]         bcnt_q, bcnt_d;
    logic [TW-1:0]      tmo_q, tmo_d;
    logic [15:0]        done_q, done_d;
    logic               eproto_q, eproto_d;
    logic               etmo_q, etmo_d;

    logic [N_REQ-1:0]   gnt;
    logic [ID_W-1:0]    gidx;
    logic               hs;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req (req_valid),
        .ptr (ptr_q),
        .en  (state_q == StIdle),
        .gnt (gnt),
        .idx (gidx)
    );

    // Grant is always a subset of req_valid, so any grant is a handshake.
    assign hs = |gnt;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        id_d       = id_q;
        dir_d      = dir_q;
        dram_d     = dram_q;
        sd_d       = sd_q;
        in_valid_d = 1'b0;
        data_d     = data_q;
        bcnt_d     = bcnt_q;
        tmo_d      = tmo_q;
        done_d     = done_q;
        eproto_d   = eproto_q;
        etmo_d     = etmo_q;

        // Stray result bytes are flagged and dropped.
        if (br_out_valid &&
            (state_q == StIdle || state_q == StIssue || state_q == StResp)) begin
            eproto_d = 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                if (hs) begin
                    id_d       = gidx;
                    ptr_d      = gidx;
                    dir_d      = req_dir[gidx];
                    dram_d     = req_addr_dram[32'(gidx)*DRAM_AW +: DRAM_AW];
                    sd_d       = req_addr_sd[32'(gidx)*SD_AW +: SD_AW];
                    in_valid_d = 1'b1;
                    state_d    = StIssue;
                end
            end
            StIssue: begin
                tmo_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (br_out_valid) begin
                    data_d  = {data_q[DATA_W-9:0], br_out_data};
                    bcnt_d  = 3'd1;
                    state_d = StCollect;
                end else begin
                    // Saturate; the bridge cannot be aborted, so only flag it.
                    if (tmo_q < TW'(TIMEOUT_CYC)) tmo_d = tmo_q + TW'(1);
                    if (tmo_d == TW'(TIMEOUT_CYC)) etmo_d = 1'b1;
                end
            end
            StCollect: begin
                if (br_out_valid) begin
                    data_d = {data_q[DATA_W-9:0], br_out_data};
                    if (bcnt_q == 3'(BR_BYTES - 1)) state_d = StResp;
                    else bcnt_d = bcnt_q + 3'd1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    done_d  = done_q + 16'd1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= ID_W'(N_REQ - 1);
            id_q       <= '0;
            dir_q      <= 1'b0;
            dram_q     <= '0;
            sd_q       <= '0;
            in_valid_q <= 1'b0;
            data_q     <= '0;
            bcnt_q     <= '0;
            tmo_q      <= '0;
            done_q     <= '0;
            eproto_q   <= 1'b0;
            etmo_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            id_q       <= id_d;
            dir_q      <= dir_d;
            dram_q     <= dram_d;
            sd_q       <= sd_d;
            in_valid_q <= in_valid_d;
            data_q     <= data_d;
            bcnt_q     <= bcnt_d;
            tmo_q      <= tmo_d;
            done_q     <= done_d;
            eproto_q   <= eproto_d;
            etmo_q     <= etmo_d;
        end
    end

    assign req_ready    = gnt;
    assign br_in_valid  = in_valid_q;
    assign br_direction = dir_q;
    assign br_addr_dram = dram_q;
    assign br_addr_sd   = sd_q;
    assign resp_valid   = (state_q == StResp);
    assign resp_id      = id_q;
    assign resp_dir     = dir_q;
    assign resp_data    = data_q;
    assign busy         = (state_q != StIdle);
    assign done_cnt     = done_q;
    assign err_proto    = eproto_q;
    assign err_timeout  = etmo_q;

endmodule

// File: tb/tb_bridge_scheduler.sv
// Directed + randomized bench for bridge_scheduler with a round-robin reference model.
module tb_bridge_scheduler;

    localparam int N   = 3;
    localparam int IDW = 2;
    localparam int TMO = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_dir = '0;
    logic [N*13-1:0] req_addr_dram = '0;
    logic [N*16-1:0] req_addr_sd = '0;
    logic            br_in_valid;
    logic            br_direction;
    logic [12:0]     br_addr_dram;
    logic [15:0]     br_addr_sd;
    logic            br_out_valid = 1'b0;
    logic [7:0]      br_out_data = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [IDW-1:0]  resp_id;
    logic            resp_dir;
    logic [63:0]     resp_data;
    logic            busy;
    logic [15:0]     done_cnt;
    logic            err_proto;
    logic            err_timeout;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int rr_ptr   = N - 1;
    int done_exp = 0;
    bit exp_proto = 1'b0;
    bit exp_tmo   = 1'b0;

    always #5 clk = ~clk;

    bridge_scheduler #(
        .N_REQ       (N),
        .ID_W        (IDW),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dir       (req_dir),
        .req_addr_dram (req_addr_dram),
        .req_addr_sd   (req_addr_sd),
        .br_in_valid   (br_in_valid),
        .br_direction  (br_direction),
        .br_addr_dram  (br_addr_dram),
        .br_addr_sd    (br_addr_sd),
        .br_out_valid  (br_out_valid),
        .br_out_data   (br_out_data),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_id       (resp_id),
        .resp_dir      (resp_dir),
        .resp_data     (resp_data),
        .busy          (busy),
        .done_cnt      (done_cnt),
        .err_proto     (err_proto),
        .err_timeout   (err_timeout)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (p + k) % N;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic d, input logic [12:0] a,
                           input logic [15:0] s);
        req_dir[i]             = d;
        req_addr_dram[13*i +: 13] = a;
        req_addr_sd[16*i +: 16]   = s;
    endtask

    task automatic rand_req(input int i);
        set_req(i, 1'($urandom), 13'($urandom), 16'($urandom));
    endtask

    // One full transfer from grant to response handshake; entered #1 after a clock edge in IDLE.
    task automatic run_xfer(input logic [63:0] word, input int wait_cyc, input bit gapped,
                            input int bp_cyc, input bit rescramble, input bit early);
        int          w;
        logic        d;
        logic [12:0] a;
        logic [15:0] s;
        logic [63:0] wv;
        #1;
        w = rr_pick(req_valid, rr_ptr);
        if (w < 0) begin
            bad++;
            $display("FAIL run_xfer: no requester valid");
            return;
        end
        chk("req_ready_grant", 64'(req_ready), 64'(1) << w);
        d = req_dir[w];
        a = req_addr_dram[13*w +: 13];
        s = req_addr_sd[16*w +: 16];
        tick();
        rr_ptr = w;
        if (rescramble) rand_req(w);
        #1;
        chk("issue_in_valid", 64'(br_in_valid), 64'(1));
        chk("issue_dir", 64'(br_direction), 64'(d));
        chk("issue_dram", 64'(br_addr_dram), 64'(a));
        chk("issue_sd", 64'(br_addr_sd), 64'(s));
        chk("issue_req_ready", 64'(req_ready), 64'(0));
        chk("issue_busy", 64'(busy), 64'(1));
        tick();
        chk("in_valid_pulse", 64'(br_in_valid), 64'(0));
        chk("wait_addr_hold", 64'(br_addr_dram), 64'(a));
        for (int i = 0; i < wait_cyc; i++) tick();
        if (wait_cyc >= TMO) exp_tmo = 1'b1;
        chk("err_timeout", 64'(err_timeout), 64'(exp_tmo));
        if (early && bp_cyc == 0) resp_ready = 1'b1;
        wv = word;
        for (int k = 0; k < 8; k++) begin
            if (gapped && k == 2) begin
                br_out_valid = 1'b0;
                tick();
                tick();
            end
            br_out_valid = 1'b1;
            br_out_data  = wv[63-8*k -: 8];
            tick();
        end
        br_out_valid = 1'b0;
        br_out_data  = '0;
        chk("resp_valid", 64'(resp_valid), 64'(1));
        chk("resp_data", resp_data, word);
        chk("resp_id", 64'(resp_id), 64'(w));
        chk("resp_dir", 64'(resp_dir), 64'(d));
        chk("err_proto", 64'(err_proto), 64'(exp_proto));
        for (int i = 0; i < bp_cyc; i++) begin
            tick();
            chk("bp_valid", 64'(resp_valid), 64'(1));
            chk("bp_data", resp_data, word);
            chk("bp_id", 64'(resp_id), 64'(w));
            chk("bp_req_ready", 64'(req_ready), 64'(0));
            chk("bp_in_valid", 64'(br_in_valid), 64'(0));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        done_exp = (done_exp + 1) % 65536;
        chk("done_cnt", 64'(done_cnt), 64'(done_exp));
        chk("post_resp_valid", 64'(resp_valid), 64'(0));
        chk("post_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rw;
        int          w;

        // Reset state
        #12;
        chk("rst_br_in_valid", 64'(br_in_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_resp_valid", 64'(resp_valid), 64'(0));
        chk("rst_done_cnt", 64'(done_cnt), 64'(0));
        chk("rst_errs", 64'({err_proto, err_timeout}), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Single request from requester 0
        set_req(0, 1'b0, 13'h0123, 16'h00A5);
        req_valid = 3'b001;
        run_xfer(64'h1122334455667788, 3, 1'b0, 0, 1'b0, 1'b0);
        req_valid = '0;

        // Contention between requesters 0 and 1
        set_req(1, 1'b1, 13'h1ABC, 16'hBEEF);
        req_valid = 3'b011;
        for (int i = 0; i < 4; i++) begin
            rw = {$urandom, $urandom};
            run_xfer(rw, int'($urandom_range(0, 5)), 1'b0, 0, 1'b0, 1'b0);
        end

        // Response backpressure, then an immediate follow-on grant
        run_xfer(64'hDEADBEEFCAFEF00D, 2, 1'b0, 10, 1'b0, 1'b0);
        run_xfer(64'h0F1E2D3C4B5A6978, 1, 1'b0, 0, 1'b0, 1'b0);
        req_valid = '0;

        // Gapped burst with resp_ready raised before resp_valid
        set_req(2, 1'b1, 13'h0F0F, 16'h1234);
        req_valid = 3'b100;
        run_xfer(64'hAABBCCDDEEFF0011, 1, 1'b1, 0, 1'b0, 1'b1);
        req_valid = '0;

        // Stray byte while idle
        chk("pre_err_proto", 64'(err_proto), 64'(0));
        br_out_valid = 1'b1;
        br_out_data  = 8'h5A;
        tick();
        br_out_valid = 1'b0;
        exp_proto = 1'b1;
        chk("stray_err_proto", 64'(err_proto), 64'(1));
        tick();
        chk("stray_no_resp", 64'(resp_valid), 64'(0));
        chk("stray_idle", 64'(busy), 64'(0));
        chk("stray_done_cnt", 64'(done_cnt), 64'(done_exp));

        // Silent bridge past the timeout, then a normal completion
        chk("pre_err_timeout", 64'(err_timeout), 64'(0));
        req_valid = 3'b001;
        run_xfer(64'h0102030405060708, 20, 1'b0, 0, 1'b0, 1'b0);
        req_valid = '0;

        // Randomized traffic
        for (int i = 0; i < N; i++) rand_req(i);
        for (int t = 0; t < 25; t++) begin
            req_valid = 3'($urandom_range(1, 7));
            rw = {$urandom, $urandom};
            run_xfer(rw, int'($urandom_range(0, 10)), 1'($urandom), int'($urandom_range(0, 3)),
                     1'b1, 1'($urandom));
        end
        req_valid = '0;
        tick();

        // Asynchronous reset in the middle of a burst
        set_req(0, 1'b1, 13'h1555, 16'hA5A5);
        set_req(1, 1'b0, 13'h0AAA, 16'h5A5A);
        req_valid = 3'b011;
        #1;
        w = rr_pick(req_valid, rr_ptr);
        tick();
        req_valid = '0;
        tick();
        for (int k = 0; k < 3; k++) begin
            br_out_valid = 1'b1;
            br_out_data  = 8'(8'hC0 + k);
            tick();
        end
        br_out_valid = 1'b0;
        chk("mid_busy", 64'(busy), 64'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_resp_data", resp_data, 64'(0));
        chk("arst_br_dram", 64'(br_addr_dram), 64'(0));
        chk("arst_br_dir", 64'(br_direction), 64'(0));
        chk("arst_done_cnt", 64'(done_cnt), 64'(0));
        chk("arst_errs", 64'({err_proto, err_timeout}), 64'(0));
        chk("arst_resp_id", 64'(resp_id), 64'(0));
        tick();
        rst_n = 1'b1;
        rr_ptr    = N - 1;
        done_exp  = 0;
        exp_proto = 1'b0;
        exp_tmo   = 1'b0;
        tick();
        req_valid = 3'b011;
        run_xfer(64'h8877665544332211, 2, 1'b0, 1, 1'b0, 1'b0);
        req_valid = '0;
        chk("post_reset_winner_was_req", 64'(w >= 0), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
